yuv_subsample_pack: RTL and testbench

- Parametrised chroma subsampler and 32-bit packer for the imager YUV pixel stream.
- Sits after uv_offset and ahead of the rotate / RAM-write stages.
- Converts 4:4:4 input pixels into packed 8-bit 4:4:4, 4:2:2 or 4:2:0 words, selected per frame.
- Passes all non-pixel dtypes (frame/row headers, meta) through in order.

---
 rtl/yuv_subsample_pack.sv | 277 +++++++++++++++++++++++++++
 tb/tb_yuv_subsample_pack.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/yuv_subsample_pack.sv
// yuv_subsample_pack
//   Chroma subsampler and 32-bit packer for the imager YUV stream.
//   Converts 4:4:4 input pixels into packed 8-bit 4:4:4, 4:2:2 or 4:2:0
//   words (mode chosen per frame) and passes non-pixel dtypes through
//   in order.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   mode         00=444, 01=422, 10=420, 11=444; sampled at FRAME_START
//   dvi          input valid
//   dtypei       input dtype (pixel dtypes have the dtype MSB set)
//   yi, ui, vi   pixel components
//   meta_datai   meta word for non-pixel dtypes
//   dvo          output valid
//   dtypeo       output dtype
//   datao        packed pixel word or zero-extended meta word
//   active_mode  mode latched for the current frame
//   error        sticky protocol-error flag

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_FRAME_START 4'h1
`define DTYPE_FRAME_END   4'h2
`define DTYPE_ROW_START   4'h3
`define DTYPE_ROW_END     4'h4
`define DTYPE_META        4'h5
`define DTYPE_PIXEL       4'h8
`endif

module yuv_subsample_pack #(
  parameter int PIXEL_WIDTH = 10,
  parameter int MAX_COLS    = 1920,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0]  yi,
  input  logic [PIXEL_WIDTH-1:0]  ui,
  input  logic [PIXEL_WIDTH-1:0]  vi,
  input  logic [DATA_WIDTH-1:0]   meta_datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [31:0]             datao,
  output logic [1:0]              active_mode,
  output logic                    error
);

  localparam int PW = PIXEL_WIDTH;
  localparam int DW = `DTYPE_WIDTH;
  localparam int CW = $clog2(MAX_COLS) + 1;
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_COLS);

  typedef enum logic [1:0] {M444 = 2'b00, M422 = 2'b01, M420 = 2'b10, MRSV = 2'b11} mode_t;
  typedef enum logic [2:0] {PK_EMPTY, PK_HAVE1, PK_L1, PK_L2, PK_L3} pk_state_t;

  function automatic logic [7:0] top8(input logic [PW-1:0] c);
    return c[PW-1 -: 8];
  endfunction

  // Rounded average at PW+1 bits; the top 8 bits of (sum >> 1) are sum[PW -: 8].
  function automatic logic [7:0] avg8(input logic [PW-1:0] c0, input logic [PW-1:0] c1);
    logic [PW:0] s;
    s = {1'b0, c0} + {1'b0, c1} + (PW+1)'(1);
    return s[PW -: 8];
  endfunction

  // Registered state
  pk_state_t             pk_state, pk_state_nxt;
  logic [7:0]            y_b0, y_b1, y_b2, y_b0_nxt, y_b1_nxt, y_b2_nxt;
  logic [PW-1:0]         u0, v0, u0_nxt, v0_nxt;
  logic [DW-1:0]         last_dt, last_dt_nxt;
  logic [CW-1:0]         col_cnt, col_nxt;
  logic                  row_par, row_par_nxt;
  logic                  prev_row_end, prev_row_end_nxt;
  logic                  hold_valid, hold_valid_nxt;
  logic [DW-1:0]         hold_dtype, hold_dtype_nxt;
  logic [PW-1:0]         hold_y, hold_u, hold_v, hold_y_nxt, hold_u_nxt, hold_v_nxt;
  logic [DATA_WIDTH-1:0] hold_meta, hold_meta_nxt;
  logic [1:0]            active_mode_nxt;
  logic                  error_nxt;
  logic                  dvo_nxt;
  logic [DW-1:0]         dtypeo_nxt;
  logic [31:0]           datao_nxt;

  // Token being processed this cycle: the hold register has priority over
  // the live input so that deferred tokens keep their order.
  logic                  cur_valid, cur_is_pix, new_pending, defer, pix_luma, pix_pack;
  logic [DW-1:0]         cur_dtype;
  logic [PW-1:0]         cur_y, cur_u, cur_v;
  logic [DATA_WIDTH-1:0] cur_meta;
  logic [7:0]            y8;
  logic [31:0]           flush_word;

  always_comb begin
    pk_state_nxt     = pk_state;
    y_b0_nxt         = y_b0;
    y_b1_nxt         = y_b1;
    y_b2_nxt         = y_b2;
    u0_nxt           = u0;
    v0_nxt           = v0;
    last_dt_nxt      = last_dt;
    col_nxt          = col_cnt;
    row_par_nxt      = row_par;
    active_mode_nxt  = active_mode;
    hold_valid_nxt   = 1'b0;
    hold_dtype_nxt   = hold_dtype;
    hold_y_nxt       = hold_y;
    hold_u_nxt       = hold_u;
    hold_v_nxt       = hold_v;
    hold_meta_nxt    = hold_meta;
    prev_row_end_nxt = dvi && (dtypei == `DTYPE_ROW_END);
    error_nxt        = error | (dvi & prev_row_end);
    defer            = 1'b0;

    cur_valid   = hold_valid | dvi;
    new_pending = hold_valid & dvi;
    cur_dtype   = hold_valid ? hold_dtype : dtypei;
    cur_y       = hold_valid ? hold_y     : yi;
    cur_u       = hold_valid ? hold_u     : ui;
    cur_v       = hold_valid ? hold_v     : vi;
    cur_meta    = hold_valid ? hold_meta  : meta_datai;
    cur_is_pix  = cur_dtype[DW-1];
    y8          = top8(cur_y);

    pix_luma = (active_mode == M420) && row_par;
    pix_pack = (active_mode == M422) || ((active_mode == M420) && !row_par);

    // A HAVE1 flush keeps the YUYV lane layout with the missing Y1 zeroed.
    case (pk_state)
      PK_HAVE1: flush_word = {y_b0, top8(u0), 8'h00, top8(v0)};
      PK_L1:    flush_word = {y_b0, 24'h0};
      PK_L2:    flush_word = {y_b0, y_b1, 16'h0};
      PK_L3:    flush_word = {y_b0, y_b1, y_b2, 8'h00};
      default:  flush_word = '0;
    endcase

    dvo_nxt    = 1'b0;
    dtypeo_nxt = cur_dtype;
    datao_nxt  = 32'(cur_meta);

    if (cur_valid) begin
      if (cur_is_pix) begin
        if (col_cnt >= COL_MAX) begin
          error_nxt = 1'b1;
        end else begin
          col_nxt     = col_cnt + CW'(1);
          last_dt_nxt = cur_dtype;
          if (pix_luma) begin
            case (pk_state)
              PK_L1: begin y_b1_nxt = y8; pk_state_nxt = PK_L2; end
              PK_L2: begin y_b2_nxt = y8; pk_state_nxt = PK_L3; end
              PK_L3: begin
                dvo_nxt      = 1'b1;
                datao_nxt    = {y_b0, y_b1, y_b2, y8};
                pk_state_nxt = PK_EMPTY;
              end
              default: begin y_b0_nxt = y8; pk_state_nxt = PK_L1; end
            endcase
          end else if (pix_pack) begin
            if (pk_state == PK_HAVE1) begin
              dvo_nxt      = 1'b1;
              datao_nxt    = {y_b0, avg8(u0, cur_u), y8, avg8(v0, cur_v)};
              pk_state_nxt = PK_EMPTY;
            end else begin
              y_b0_nxt     = y8;
              u0_nxt       = cur_u;
              v0_nxt       = cur_v;
              pk_state_nxt = PK_HAVE1;
            end
          end else begin
            dvo_nxt   = 1'b1;
            datao_nxt = {8'h00, y8, top8(cur_u), top8(cur_v)};
          end
        end
      end else begin
        dvo_nxt = 1'b1;
        case (cur_dtype)
          `DTYPE_FRAME_START: begin
            active_mode_nxt = mode;
            row_par_nxt     = 1'b0;
            col_nxt         = '0;
            pk_state_nxt    = PK_EMPTY;
          end
          `DTYPE_ROW_START: begin
            col_nxt      = '0;
            pk_state_nxt = PK_EMPTY;
          end
          `DTYPE_ROW_END: begin
            if (pk_state != PK_EMPTY) begin
              // Flush now; the ROW_END itself is replayed from the hold
              // register next cycle, where it finds the pack state empty.
              dtypeo_nxt   = last_dt;
              datao_nxt    = flush_word;
              pk_state_nxt = PK_EMPTY;
              defer        = 1'b1;
            end else begin
              row_par_nxt = ~row_par;
            end
          end
          default: ;
        endcase
      end
    end

    if (defer) begin
      hold_valid_nxt = 1'b1;
      hold_dtype_nxt = cur_dtype;
      hold_meta_nxt  = cur_meta;
      if (new_pending) error_nxt = 1'b1;
    end else if (new_pending) begin
      error_nxt = 1'b1;
      // Only a collision with a held ROW_END is delayed; a second back-to-back
      // collision (hold still busy with a delayed input) drops the new input.
      if (hold_dtype == `DTYPE_ROW_END) begin
        hold_valid_nxt = 1'b1;
        hold_dtype_nxt = dtypei;
        hold_y_nxt     = yi;
        hold_u_nxt     = ui;
        hold_v_nxt     = vi;
        hold_meta_nxt  = meta_datai;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pk_state     <= PK_EMPTY;
      y_b0         <= '0;
      y_b1         <= '0;
      y_b2         <= '0;
      u0           <= '0;
      v0           <= '0;
      last_dt      <= '0;
      col_cnt      <= '0;
      row_par      <= 1'b0;
      prev_row_end <= 1'b0;
      hold_valid   <= 1'b0;
      hold_dtype   <= '0;
      hold_y       <= '0;
      hold_u       <= '0;
      hold_v       <= '0;
      hold_meta    <= '0;
      active_mode  <= 2'b00;
      error        <= 1'b0;
      dvo          <= 1'b0;
      dtypeo       <= '0;
      datao        <= '0;
    end else begin
      pk_state     <= pk_state_nxt;
      y_b0         <= y_b0_nxt;
      y_b1         <= y_b1_nxt;
      y_b2         <= y_b2_nxt;
      u0           <= u0_nxt;
      v0           <= v0_nxt;
      last_dt      <= last_dt_nxt;
      col_cnt      <= col_nxt;
      row_par      <= row_par_nxt;
      prev_row_end <= prev_row_end_nxt;
      hold_valid   <= hold_valid_nxt;
      hold_dtype   <= hold_dtype_nxt;
      hold_y       <= hold_y_nxt;
      hold_u       <= hold_u_nxt;
      hold_v       <= hold_v_nxt;
      hold_meta    <= hold_meta_nxt;
      active_mode  <= active_mode_nxt;
      error        <= error_nxt;
      dvo          <= dvo_nxt;
      dtypeo       <= dtypeo_nxt;
      datao        <= datao_nxt;
    end
  end

endmodule

// File: tb/tb_yuv_subsample_pack.sv
// Testbench for yuv_subsample_pack: directed vectors, scoreboard queues and
// negedge monitors. Instance a uses MAX_COLS=8, instance b MAX_COLS=4.
module tb_yuv_subsample_pack;

  localparam logic [3:0] FS   = 4'h1;
  localparam logic [3:0] RS   = 4'h3;
  localparam logic [3:0] RE   = 4'h4;
  localparam logic [3:0] MT   = 4'h5;
  localparam logic [3:0] PIX  = 4'h8;
  localparam logic [3:0] PIX2 = 4'h9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        dvi_a = 1'b0, dvi_b = 1'b0;
  logic [3:0]  dtypei = '0;
  logic [9:0]  yi = '0, ui = '0, vi = '0;
  logic [15:0] meta_datai = '0;

  logic        dvo_a, dvo_b, error_a, error_b;
  logic [3:0]  dtypeo_a, dtypeo_b;
  logic [31:0] datao_a, datao_b;
  logic [1:0]  am_a, am_b;

  int total = 0;
  int bad = 0;
  logic [35:0] exp_a[$];
  logic [35:0] exp_b[$];

  always #5 clk = ~clk;

  yuv_subsample_pack #(.PIXEL_WIDTH(10), .MAX_COLS(8), .DATA_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .dvi(dvi_a), .dtypei(dtypei),
    .yi(yi), .ui(ui), .vi(vi), .meta_datai(meta_datai),
    .dvo(dvo_a), .dtypeo(dtypeo_a), .datao(datao_a),
    .active_mode(am_a), .error(error_a));

  yuv_subsample_pack #(.PIXEL_WIDTH(10), .MAX_COLS(4), .DATA_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .mode(mode), .dvi(dvi_b), .dtypei(dtypei),
    .yi(yi), .ui(ui), .vi(vi), .meta_datai(meta_datai),
    .dvo(dvo_b), .dtypeo(dtypeo_b), .datao(datao_b),
    .active_mode(am_b), .error(error_b));

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (dvo_a) begin
      if (exp_a.size() == 0) check("a_unexpected", {dtypeo_a, datao_a}, 36'hx);
      else check("a_out", {dtypeo_a, datao_a}, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dvo_b) begin
      if (exp_b.size() == 0) check("b_unexpected", {dtypeo_b, datao_b}, 36'hx);
      else check("b_out", {dtypeo_b, datao_b}, exp_b.pop_front());
    end
  end

  task automatic put(input bit sel_b, input logic [3:0] dt, input logic [9:0] y,
                     input logic [9:0] u, input logic [9:0] v, input logic [15:0] meta);
    dtypei = dt; yi = y; ui = u; vi = v; meta_datai = meta;
    if (sel_b) dvi_b = 1'b1; else dvi_a = 1'b1;
    @(posedge clk); #1;
    dvi_a = 1'b0; dvi_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Control token on instance a with its pass-through expectation.
  task automatic ctl_a(input logic [3:0] dt, input logic [15:0] meta);
    exp_a.push_back({dt, 16'h0, meta});
    put(1'b0, dt, '0, '0, '0, meta);
  endtask

  // 8-bit luma placed in the top bits of a 10-bit sample.
  function automatic logic [9:0] y10(input logic [7:0] y);
    return {y, 2'b00};
  endfunction

  initial begin
    idle(3);
    // Reset state
    check("rst_dvo", {35'h0, dvo_a}, 36'h0);
    check("rst_data", {dtypeo_a, datao_a}, 36'h0);
    check("rst_mode_err", {33'h0, am_a, error_a}, 36'h0);
    reset = 1'b0;
    idle(2);

    // 444
    mode = 2'b00;
    ctl_a(FS, 16'h1234);
    ctl_a(RS, 16'h0001);
    exp_a.push_back({PIX, 32'h00FF8001});
    put(1'b0, PIX, 10'h3FC, 10'h200, 10'h004, '0);
    ctl_a(RE, 16'h0002);
    idle(2);

    // 422 averaging, mode shadowing and HAVE1 flush with raw U0/V0
    mode = 2'b01;
    ctl_a(FS, 16'h0010);
    check("am_422", {34'h0, am_a}, 36'h1);
    ctl_a(RS, 16'h0011);
    put(1'b0, PIX, y10(8'hA0), 10'h100, 10'h3FF, '0);
    exp_a.push_back({PIX2, 32'hA040B080});
    put(1'b0, PIX2, y10(8'hB0), 10'h101, 10'h001, '0);
    mode = 2'b00;
    put(1'b0, PIX, y10(8'hC0), 10'h3FC, 10'h000, '0);
    exp_a.push_back({PIX, 32'hC0FF0000});
    ctl_a(RE, 16'h0012);
    idle(2);
    check("am_shadow", {34'h0, am_a}, 36'h1);
    ctl_a(FS, 16'h0013);
    check("am_new_frame", {34'h0, am_a}, 36'h0);
    idle(1);

    // 420: even row YUYV, odd row luma with flush
    mode = 2'b10;
    ctl_a(FS, 16'h0020);
    ctl_a(RS, 16'h0021);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) exp_a.push_back({PIX, 8'(8'h10 * i), 8'h40, 8'(8'h10 * (i + 1)), 8'h80});
      put(1'b0, PIX, y10(8'(8'h10 * (i + 1))), 10'h100, 10'h200, '0);
    end
    ctl_a(RE, 16'h0022);
    idle(1);
    ctl_a(RS, 16'h0023);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) exp_a.push_back({PIX, 32'h11121314});
      put(1'b0, PIX, y10(8'(8'h11 + i)), 10'h3FF, 10'h3FF, '0);
    end
    exp_a.push_back({PIX, 32'h15160000});
    ctl_a(RE, 16'h0024);
    check("re_deferred", {35'h0, dvo_a}, 36'h1);
    idle(2);

    // Pixel right after ROW_END: held ROW_END goes first, pixel follows
    check("err_before", {35'h0, error_a}, 36'h0);
    ctl_a(RS, 16'h0030);
    put(1'b0, PIX, y10(8'h21), 10'h100, 10'h200, '0);
    exp_a.push_back({PIX, 32'h21400080});
    ctl_a(RE, 16'h0031);
    put(1'b0, PIX, y10(8'h22), 10'h000, 10'h000, '0);
    idle(1);
    check("err_collision", {35'h0, error_a}, 36'h1);
    exp_a.push_back({PIX, 32'h22000000});
    ctl_a(RE, 16'h0032);
    idle(2);

    // Column overflow on the MAX_COLS=4 instance
    mode = 2'b00;
    exp_b.push_back({FS, 32'h00000040});
    put(1'b1, FS, '0, '0, '0, 16'h0040);
    exp_b.push_back({RS, 32'h00000041});
    put(1'b1, RS, '0, '0, '0, 16'h0041);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("b_err_before", {35'h0, error_b}, 36'h0);
      if (i < 4) exp_b.push_back({PIX, 8'h00, 8'(8'h31 + i), 8'h20, 8'h08});
      put(1'b1, PIX, y10(8'(8'h31 + i)), 10'h080, 10'h020, '0);
    end
    check("b_err_overflow", {35'h0, error_b}, 36'h1);
    exp_b.push_back({RE, 32'h00000042});
    put(1'b1, RE, '0, '0, '0, 16'h0042);
    idle(2);

    // Reset mid-row in 422 HAVE1; the meta word in flight is discarded
    mode = 2'b01;
    ctl_a(FS, 16'h0050);
    ctl_a(RS, 16'h0051);
    put(1'b0, PIX, y10(8'h55), 10'h100, 10'h100, '0);
    put(1'b0, MT, '0, '0, '0, 16'h0052);
    reset = 1'b1;
    #1;
    check("rst_mid_dvo", {35'h0, dvo_a}, 36'h0);
    check("rst_mid_state", {dtypeo_a, datao_a}, 36'h0);
    check("rst_mid_mode_err", {33'h0, am_a, error_a}, 36'h0);
    idle(2);
    reset = 1'b0;
    idle(1);
    ctl_a(FS, 16'h0060);
    ctl_a(RS, 16'h0061);
    put(1'b0, PIX, y10(8'h66), 10'h100, 10'h200, '0);
    exp_a.push_back({PIX, 32'h66407780});
    put(1'b0, PIX, y10(8'h77), 10'h100, 10'h200, '0);
    ctl_a(RE, 16'h0062);
    idle(4);

    check("a_drained", 36'(exp_a.size()), 36'h0);
    check("b_drained", 36'(exp_b.size()), 36'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
